ascon_perm_iter: RTL

Sequential round engine for the ASCON-128 permutation. It holds the 320-bit state in a register and applies the single-round permutation `p` once per clock. Each run executes p12 (round indices 0..11) or p6 (indices 6..11), with optional data XOR into S0 at load and key XOR into S3/S4 on the final round. It sits between the mode controller (upstream: supplies state, data, key and start) and the tag/ciphertext logic (downstream: consumes `state_o` on `done_o`).

---
 rtl/ascon_pack.sv | 21 ++
 rtl/ascon_perm_iter_p.sv | 43 ++++
 rtl/ascon_perm_iter.sv | 107 ++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation round engine.
package ascon_pack;

  // S0 is element 0, so {S0, S1, S2, S3, S4} concatenates naturally.
  typedef logic [0:4][63:0] type_state;

  localparam logic [3:0] ROUND_START_P12 = 4'd0;
  localparam logic [3:0] ROUND_START_P6  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } type_fsm;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_iter_p.sv
// Single combinational ASCON round: constant addition, bitsliced 5-bit S-box,
// and the per-word linear diffusion layer.
module ascon_perm_iter_p
  import ascon_pack::*;
(
  input  type_state  pin_i,
  input  logic [3:0] round_i,
  output type_state  pout_o
);

  logic [7:0]  rc;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  assign rc = {4'hf - round_i, round_i};

  // Round constant folded into the S-box input xors on S2.
  assign a0 = pin_i[0] ^ pin_i[4];
  assign a1 = pin_i[1];
  assign a2 = pin_i[2] ^ {56'd0, rc} ^ pin_i[1];
  assign a3 = pin_i[3];
  assign a4 = pin_i[4] ^ pin_i[3];

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign c0 = b0 ^ b4;
  assign c1 = b1 ^ b0;
  assign c2 = ~b2;
  assign c3 = b3 ^ b2;
  assign c4 = b4;

  assign pout_o[0] = c0 ^ rotr(c0, 19) ^ rotr(c0, 28);
  assign pout_o[1] = c1 ^ rotr(c1, 61) ^ rotr(c1, 39);
  assign pout_o[2] = c2 ^ rotr(c2, 1)  ^ rotr(c2, 6);
  assign pout_o[3] = c3 ^ rotr(c3, 10) ^ rotr(c3, 17);
  assign pout_o[4] = c4 ^ rotr(c4, 7)  ^ rotr(c4, 41);

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative ASCON p12/p6 engine, one round per clock.
// Optional key latch and final-round S3/S4 key XOR under ASCON_PERM_KEY_XOR_EN.
//
// state | meaning
// IDLE  | waiting for start_i; state_o holds last result
// RUN   | one round per cycle, cnt = round index
// DONE  | single-cycle done_o pulse with the result in state_o
module ascon_perm_iter
  import ascon_pack::*;
(
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         p6_i,
  input  type_state    state_i,
  input  logic [63:0]  data_i,
  input  logic         xor_data_i,
  input  logic [127:0] key_i,
  input  logic         xor_key_i,
  output type_state    state_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   round_o
);

  type_fsm    fsm_q, fsm_d;
  type_state  state_q, state_d, p_out;
  logic [3:0] cnt_q, cnt_d;

  ascon_perm_iter_p u_round (
    .pin_i   (state_q),
    .round_i (cnt_q),
    .pout_o  (p_out)
  );

`ifdef ASCON_PERM_KEY_XOR_EN
  logic [127:0] key_q;
  logic         xor_key_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      key_q     <= '0;
      xor_key_q <= 1'b0;
    end else if (fsm_q == IDLE && start_i) begin
      key_q     <= key_i;
      xor_key_q <= xor_key_i;
    end
  end
`else
  logic unused_key;
  assign unused_key = ^{key_i, xor_key_i};
`endif

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          if (xor_data_i) state_d[0] = state_i[0] ^ data_i;
          cnt_d = p6_i ? ROUND_START_P6 : ROUND_START_P12;
          fsm_d = RUN;
        end
      end
      RUN: begin
        busy_o  = 1'b1;
        state_d = p_out;
        if (cnt_q == ROUND_LAST) begin
`ifdef ASCON_PERM_KEY_XOR_EN
          if (xor_key_q) begin
            state_d[3] = p_out[3] ^ key_q[127:64];
            state_d[4] = p_out[4] ^ key_q[63:0];
          end
`endif
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        done_o = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign round_o = cnt_q;

endmodule
